// File: rtl/instr_enc_pkg.sv
// Shared encodings for the MSP430 instruction-stream writer: formats, As modes, FMT_II opcodes.
// Pure declarations plus one combinational word-0 packer; no state.
// No flow control here; consumers own all handshaking.
package instr_enc_pkg;

    // Descriptor format field
    localparam logic [1:0] FMT_ILL = 2'd0;
    localparam logic [1:0] FMT_I   = 2'd1;
    localparam logic [1:0] FMT_II  = 2'd2;
    localparam logic [1:0] FMT_J   = 2'd3;

    // Source addressing modes (As)
    localparam logic [1:0] AS_REG = 2'b00;
    localparam logic [1:0] AS_IDX = 2'b01;
    localparam logic [1:0] AS_IND = 2'b10;
    localparam logic [1:0] AS_INC = 2'b11;

    // Registers with special source-operand meaning
    localparam logic [3:0] REG_PC = 4'd0;
    localparam logic [3:0] REG_SR = 4'd2;
    localparam logic [3:0] REG_CG = 4'd3;

    // Lowest legal double-operand opcode (MOV)
    localparam logic [3:0] OP_FMT_I_MIN = 4'h4;

    // Single-operand opcode field codes; 3'b111 is unassigned
    localparam logic [2:0] OP2_RRC  = 3'd0;
    localparam logic [2:0] OP2_SWPB = 3'd1;
    localparam logic [2:0] OP2_RRA  = 3'd2;
    localparam logic [2:0] OP2_SXT  = 3'd3;
    localparam logic [2:0] OP2_PUSH = 3'd4;
    localparam logic [2:0] OP2_CALL = 3'd5;
    localparam logic [2:0] OP2_RETI = 3'd6;
    localparam logic [2:0] OP2_ILL  = 3'd7;

    // Writer sequencing states: opcode word, then optional src ext, then optional dst ext
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OP   = 2'd1,
        ST_SRC  = 2'd2,
        ST_DST  = 2'd3
    } enc_state_t;

    // Build the opcode word exactly as the decoder expects it off MDB
    function automatic logic [15:0] pack_word0(
        input logic [1:0] fmt,
        input logic [3:0] op,
        input logic [3:0] sreg,
        input logic [3:0] dreg,
        input logic [1:0] as_mode,
        input logic       ad,
        input logic       bw,
        input logic [9:0] jmp_off
    );
        logic [15:0] w;
        case (fmt)
            FMT_I:   w = {op, sreg, ad, bw, as_mode, dreg};
            FMT_II:  w = {6'b000100, op[2:0], bw, as_mode, sreg};
            FMT_J:   w = {3'b001, op[2:0], jmp_off};
            default: w = 16'h0000;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/instr_enc_ext_word_calc.sv
// Classifies a descriptor: which extension words follow the opcode word, and whether it is illegal.
// Purely combinational, zero latency.
// No backpressure; evaluated on the live descriptor inputs.
module instr_enc_ext_word_calc
    import instr_enc_pkg::*;
(
    input  logic [1:0] i_fmt,
    input  logic [3:0] i_op,
    input  logic [3:0] i_sreg,
    input  logic [1:0] i_as,
    input  logic       i_ad,
    output logic       o_need_src,
    output logic       o_need_dst,
    output logic       o_illegal
);

    logic w_has_src;

    // Constant-generator encodings (R3 any mode, R2 with As>=10) never carry an ext word;
    // R2 with As=01 is absolute addressing and does.
    always_comb begin
        w_has_src  = (i_fmt == FMT_I) || (i_fmt == FMT_II);
        o_need_src = w_has_src &&
                     (((i_as == AS_IDX) && (i_sreg != REG_CG)) ||
                      ((i_as == AS_INC) && (i_sreg == REG_PC)));
        o_need_dst = (i_fmt == FMT_I) && i_ad;
        o_illegal  = (i_fmt == FMT_ILL) ||
                     ((i_fmt == FMT_I)  && (i_op < OP_FMT_I_MIN)) ||
                     ((i_fmt == FMT_II) && (i_op[2:0] == OP2_ILL));
    end

endmodule

// File: rtl/instr_enc.sv
// Packs one instruction descriptor into 1-3 ROM words written at consecutive even addresses.
// Latency: first write request one cycle after accept; done one cycle after the last word is taken.
// Backpressure: each word holds addr/data until wr_ready; descriptors accepted only while idle.
module instr_enc
    import instr_enc_pkg::*;
#(
    parameter logic [15:0] START_ADDR = 16'h0000
)(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_org_load,
    input  logic [15:0] i_org_addr,
    input  logic        i_in_valid,
    output logic        o_in_ready,
    input  logic [1:0]  i_in_fmt,
    input  logic [3:0]  i_in_op,
    input  logic [3:0]  i_in_sreg,
    input  logic [3:0]  i_in_dreg,
    input  logic [1:0]  i_in_as,
    input  logic        i_in_ad,
    input  logic        i_in_bw,
    input  logic [15:0] i_in_src_ext,
    input  logic [15:0] i_in_dst_ext,
    input  logic [9:0]  i_in_jmp_off,
    output logic        o_wr_valid,
    input  logic        i_wr_ready,
    output logic [15:0] o_wr_addr,
    output logic [15:0] o_wr_data,
    output logic        o_done,
    output logic        o_err
);

    localparam logic [15:0] ADDR_MASK  = 16'hFFFE;
    localparam logic [15:0] RESET_ADDR = START_ADDR & ADDR_MASK;
    localparam logic [15:0] WORD_BYTES = 16'd2;

    enc_state_t  r_state;
    logic        r_in_ready;
    logic        r_wr_valid;
    logic [15:0] r_wr_addr;
    logic [15:0] r_wr_data;
    logic        r_done;
    logic        r_err;
    logic [15:0] r_src_ext;
    logic [15:0] r_dst_ext;
    logic        r_need_src;
    logic        r_need_dst;

    logic        w_need_src;
    logic        w_need_dst;
    logic        w_illegal;
    logic [15:0] w_word0;
    logic [15:0] w_base_addr;
    logic [15:0] w_next_addr;

    instr_enc_ext_word_calc u_ext_word_calc (
        .i_fmt      (i_in_fmt),
        .i_op       (i_in_op),
        .i_sreg     (i_in_sreg),
        .i_as       (i_in_as),
        .i_ad       (i_in_ad),
        .o_need_src (w_need_src),
        .o_need_dst (w_need_dst),
        .o_illegal  (w_illegal)
    );

    assign w_word0     = pack_word0(i_in_fmt, i_in_op, i_in_sreg, i_in_dreg,
                                    i_in_as, i_in_ad, i_in_bw, i_in_jmp_off);
    // An org load in the same idle cycle as a descriptor takes effect first
    assign w_base_addr = i_org_load ? (i_org_addr & ADDR_MASK) : r_wr_addr;
    // 16-bit add wraps 0xFFFE to 0x0000
    assign w_next_addr = r_wr_addr + WORD_BYTES;

    // Sequencer: accept in idle, then step through opcode/src/dst words one handshake at a time
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_in_ready <= 1'b1;
            r_wr_valid <= 1'b0;
            r_wr_addr  <= RESET_ADDR;
            r_wr_data  <= 16'h0000;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_src_ext  <= 16'h0000;
            r_dst_ext  <= 16'h0000;
            r_need_src <= 1'b0;
            r_need_dst <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_wr_addr <= w_base_addr;
                    if (i_in_valid) begin
                        if (w_illegal) begin
                            r_err <= 1'b1;
                        end else begin
                            r_state    <= ST_OP;
                            r_in_ready <= 1'b0;
                            r_wr_valid <= 1'b1;
                            r_wr_data  <= w_word0;
                            r_src_ext  <= i_in_src_ext;
                            r_dst_ext  <= i_in_dst_ext;
                            r_need_src <= w_need_src;
                            r_need_dst <= w_need_dst;
                        end
                    end
                end
                ST_OP: begin
                    if (i_wr_ready) begin
                        r_wr_addr <= w_next_addr;
                        if (r_need_src) begin
                            r_state   <= ST_SRC;
                            r_wr_data <= r_src_ext;
                        end else if (r_need_dst) begin
                            r_state   <= ST_DST;
                            r_wr_data <= r_dst_ext;
                        end else begin
                            r_state    <= ST_IDLE;
                            r_wr_valid <= 1'b0;
                            r_in_ready <= 1'b1;
                            r_done     <= 1'b1;
                        end
                    end
                end
                ST_SRC: begin
                    if (i_wr_ready) begin
                        r_wr_addr <= w_next_addr;
                        if (r_need_dst) begin
                            r_state   <= ST_DST;
                            r_wr_data <= r_dst_ext;
                        end else begin
                            r_state    <= ST_IDLE;
                            r_wr_valid <= 1'b0;
                            r_in_ready <= 1'b1;
                            r_done     <= 1'b1;
                        end
                    end
                end
                ST_DST: begin
                    if (i_wr_ready) begin
                        r_wr_addr  <= w_next_addr;
                        r_state    <= ST_IDLE;
                        r_wr_valid <= 1'b0;
                        r_in_ready <= 1'b1;
                        r_done     <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_wr_valid <= 1'b0;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

    assign o_in_ready = r_in_ready;
    assign o_wr_valid = r_wr_valid;
    assign o_wr_addr  = r_wr_addr;
    assign o_wr_data  = r_wr_data;
    assign o_done     = r_done;
    assign o_err      = r_err;

endmodule

// File: tb/tb_instr_enc.sv
// Bench for instr_enc: directed spec cases then randomized descriptors against a word-list model.
// Inputs driven and outputs sampled 1 time unit after each rising edge.
// Write-side backpressure is exercised with held-off and random wr_ready.
module tb_instr_enc;

    logic        clk = 1'b0;
    logic        rst;
    logic        org_load;
    logic [15:0] org_addr;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_fmt;
    logic [3:0]  in_op;
    logic [3:0]  in_sreg;
    logic [3:0]  in_dreg;
    logic [1:0]  in_as;
    logic        in_ad;
    logic        in_bw;
    logic [15:0] in_src_ext;
    logic [15:0] in_dst_ext;
    logic [9:0]  in_jmp_off;
    logic        wr_valid;
    logic        wr_ready;
    logic [15:0] wr_addr;
    logic [15:0] wr_data;
    logic        done;
    logic        err;

    localparam logic [15:0] START = 16'h0101;
    localparam logic [15:0] START_EVEN = 16'h0100;

    int n_tests = 0;
    int n_fail  = 0;
    logic [15:0] exp_ptr;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    instr_enc #(.START_ADDR(START)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_org_load   (org_load),
        .i_org_addr   (org_addr),
        .i_in_valid   (in_valid),
        .o_in_ready   (in_ready),
        .i_in_fmt     (in_fmt),
        .i_in_op      (in_op),
        .i_in_sreg    (in_sreg),
        .i_in_dreg    (in_dreg),
        .i_in_as      (in_as),
        .i_in_ad      (in_ad),
        .i_in_bw      (in_bw),
        .i_in_src_ext (in_src_ext),
        .i_in_dst_ext (in_dst_ext),
        .i_in_jmp_off (in_jmp_off),
        .o_wr_valid   (wr_valid),
        .i_wr_ready   (wr_ready),
        .o_wr_addr    (wr_addr),
        .o_wr_data    (wr_data),
        .o_done       (done),
        .o_err        (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_desc(input int fmt, input int op, input int sreg, input int dreg,
                            input int as_m, input int ad, input int bw,
                            input int sx, input int dx, input int off);
        in_fmt     = fmt[1:0];
        in_op      = op[3:0];
        in_sreg    = sreg[3:0];
        in_dreg    = dreg[3:0];
        in_as      = as_m[1:0];
        in_ad      = ad[0];
        in_bw      = bw[0];
        in_src_ext = sx[15:0];
        in_dst_ext = dx[15:0];
        in_jmp_off = off[9:0];
    endtask

    // Reference: list of ROM words for the current descriptor (empty = illegal)
    function automatic void model();
        int f, op, s, d, a, w0;
        f  = int'(in_fmt);
        op = int'(in_op);
        s  = int'(in_sreg);
        d  = int'(in_dreg);
        a  = int'(in_as);
        exp_q.delete();
        if (f == 0) return;
        if (f == 1 && op < 4) return;
        if (f == 2 && (op % 8) == 7) return;
        if (f == 1)
            w0 = op * 4096 + s * 256 + int'(in_ad) * 128 + int'(in_bw) * 64 + a * 16 + d;
        else if (f == 2)
            w0 = 4096 + (op % 8) * 128 + int'(in_bw) * 64 + a * 16 + s;
        else
            w0 = 8192 + (op % 8) * 1024 + int'(in_jmp_off);
        exp_q.push_back(w0[15:0]);
        if (f != 3 && ((a == 1 && s != 3) || (a == 3 && s == 0)))
            exp_q.push_back(in_src_ext);
        if (f == 1 && in_ad)
            exp_q.push_back(in_dst_ext);
    endfunction

    // stall_mode: 0 ready at once, 1 random 0-2 low cycles, 2 three low cycles on word index 1
    task automatic issue(input logic org_ld, input logic [15:0] org_a, input int stall_mode,
                         input string tag);
        int budget;
        int stalls;
        model();
        if (org_ld) exp_ptr = org_a & 16'hFFFE;
        budget = 0;
        while (in_ready !== 1'b1 && budget < 20) begin
            step();
            budget++;
        end
        chk({tag, " in_ready"}, in_ready, 1);
        in_valid = 1'b1;
        org_load = org_ld;
        org_addr = org_a;
        wr_ready = 1'b0;
        step();
        in_valid = 1'b0;
        org_load = 1'b0;
        if (exp_q.size() == 0) begin
            chk({tag, " err"}, err, 1);
            chk({tag, " no wr_valid"}, wr_valid, 0);
            chk({tag, " idle ready"}, in_ready, 1);
            chk({tag, " ptr"}, wr_addr, exp_ptr);
            step();
            chk({tag, " err drop"}, err, 0);
            chk({tag, " still no wr"}, wr_valid, 0);
            return;
        end
        chk({tag, " no err"}, err, 0);
        for (int k = 0; k < exp_q.size(); k++) begin
            stalls = (stall_mode == 1) ? int'($urandom_range(0, 2)) :
                     (stall_mode == 2 && k == 1) ? 3 : 0;
            for (int s = 0; s < stalls; s++) begin
                chk({tag, " hold vld"}, wr_valid, 1);
                chk({tag, " hold addr"}, wr_addr, exp_ptr);
                chk({tag, " hold data"}, wr_data, exp_q[k]);
                step();
            end
            chk({tag, " wr_valid"}, wr_valid, 1);
            chk({tag, " wr_addr"}, wr_addr, exp_ptr);
            chk({tag, " wr_data"}, wr_data, exp_q[k]);
            chk({tag, " early done"}, done, 0);
            wr_ready = 1'b1;
            step();
            wr_ready = 1'b0;
            exp_ptr = exp_ptr + 16'd2;
        end
        chk({tag, " done"}, done, 1);
        chk({tag, " wr_valid off"}, wr_valid, 0);
        chk({tag, " ready back"}, in_ready, 1);
        chk({tag, " next ptr"}, wr_addr, exp_ptr);
        step();
        chk({tag, " done pulse"}, done, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; org_load = 1'b0; org_addr = 16'h0; in_valid = 1'b0; wr_ready = 1'b0;
        set_desc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(); step();
        rst = 1'b0;
        chk("reset in_ready", in_ready, 1);
        chk("reset wr_valid", wr_valid, 0);
        chk("reset wr_addr", wr_addr, START_EVEN);
        chk("reset wr_data", wr_data, 0);
        chk("reset done", done, 0);
        chk("reset err", err, 0);
        exp_ptr = START_EVEN;
        step();
        chk("idle addr held", wr_addr, START_EVEN);

        set_desc(1, 4, 5, 6, 0, 0, 0, 0, 0, 0);                 // MOV R5,R6
        issue(1'b1, 16'h0000, 0, "mov_rr");
        set_desc(1, 4, 0, 7, 3, 0, 0, 16'h1234, 0, 0);          // MOV #0x1234,R7
        issue(1'b1, 16'h0000, 0, "mov_imm");
        set_desc(1, 5, 5, 6, 1, 1, 0, 16'h0004, 16'h0008, 0);   // ADD 4(R5),8(R6)
        issue(1'b1, 16'h0000, 2, "add_idx");
        set_desc(1, 4, 3, 4, 1, 0, 0, 16'hDEAD, 0, 0);          // MOV #1,R4 via CG
        issue(1'b0, 16'h0000, 0, "mov_cg");
        set_desc(1, 4, 2, 4, 3, 0, 0, 16'hBEEF, 0, 0);          // MOV #8,R4 via CG (R2)
        issue(1'b0, 16'h0000, 0, "mov_cg2");
        set_desc(1, 4, 2, 4, 1, 0, 0, 16'h0200, 0, 0);          // MOV &0x200,R4
        issue(1'b0, 16'h0000, 1, "mov_abs");
        set_desc(2, 0, 5, 0, 0, 0, 0, 0, 0, 0);                 // RRC R5
        issue(1'b0, 16'h0000, 0, "rrc");
        set_desc(3, 7, 0, 0, 0, 0, 0, 0, 0, 10'h3FF);           // JMP cond7
        issue(1'b0, 16'h0000, 0, "jmp");
        set_desc(1, 4, 0, 7, 3, 0, 0, 16'h5A5A, 0, 0);          // wrap at top of memory
        issue(1'b1, 16'hFFFF, 2, "wrap");
        set_desc(0, 4, 5, 6, 0, 0, 0, 0, 0, 0);
        issue(1'b0, 16'h0000, 0, "fmt0");
        set_desc(1, 3, 5, 6, 0, 0, 0, 0, 0, 0);
        issue(1'b1, 16'h0040, 0, "fmt1_op3");
        set_desc(2, 7, 5, 0, 0, 0, 0, 0, 0, 0);
        issue(1'b0, 16'h0000, 0, "fmt2_op7");

        // Reset while the src ext word is pending
        set_desc(1, 4, 0, 7, 3, 0, 0, 16'h1234, 0, 0);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        wr_ready = 1'b1;
        step();
        wr_ready = 1'b0;
        chk("rst_src pending data", wr_data, 16'h1234);
        chk("rst_src pending vld", wr_valid, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_src wr_valid", wr_valid, 0);
        chk("rst_src wr_addr", wr_addr, START_EVEN);
        chk("rst_src in_ready", in_ready, 1);
        step();
        chk("rst_src stays idle", wr_valid, 0);
        chk("rst_src no done", done, 0);
        exp_ptr = START_EVEN;

        for (int i = 0; i < 60; i++) begin
            set_desc(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
                     int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
                     int'($urandom_range(0, 1)), int'($urandom_range(0, 65535)),
                     int'($urandom_range(0, 65535)), int'($urandom_range(0, 1023)));
            issue(($urandom_range(0, 7) == 0), 16'($urandom_range(0, 65535)),
                  int'($urandom_range(0, 1)), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
